// File: rtl/pu_riscv_bp.sv
// pu_riscv_bp -- branch predictor built on a pattern history table of 2-bit
// saturating counters.
//
// The table index combines the global history with the PC slice.
// Handshake: there is no valid/ready pair on the datapath.
// - bp_ready is a level. It is low while the table is being initialised and
//   high once predictions are meaningful.
// - A lookup is accepted on every clock edge where the block is ready and
//   if_stall is low.
// - bu_bp_update is a single-cycle write strobe.
//
// Build option: define PU_RISCV_BP_GSHARE_EN to XOR the history into the top
// index bits (gshare). Leave it undefined to concatenate the history with
// the PC slice.
module pu_riscv_bp #(
    parameter int XLEN           = 64,
    parameter int BP_GLOBAL_BITS = 2,
    parameter int BP_LOCAL_BITS  = 10,
    parameter int HAS_RVC        = 1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      if_stall,
    input  logic [XLEN-1:0]           if_nxt_pc,
    output logic [1:0]                bp_bp_predict,
    output logic                      bp_ready,
    input  logic [XLEN-1:0]           ex_pc,
    input  logic [BP_GLOBAL_BITS-1:0] bu_bp_history,
    input  logic [1:0]                bu_bp_predict,
    input  logic                      bu_bp_btaken,
    input  logic                      bu_bp_update
);

    localparam int IDX   = BP_GLOBAL_BITS + BP_LOCAL_BITS;
    localparam int DEPTH = 1 << IDX;
    localparam int LSB   = (HAS_RVC != 0) ? 1 : 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IDX-1:0]   init_cnt_q;
    logic [IDX-1:0]   rd_idx, wr_idx;
    logic [1:0]       upd_val;
    logic             wr_en;
    logic [IDX-1:0]   wr_addr;
    logic [1:0]       wr_data;
    logic [1:0]       pht [DEPTH];

    // PC bits above the slice alias onto the same entries.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_nxt_pc, ex_pc};

`ifdef PU_RISCV_BP_GSHARE_EN
    assign rd_idx = if_nxt_pc[LSB+IDX-1:LSB] ^ {bu_bp_history, {BP_LOCAL_BITS{1'b0}}};
    assign wr_idx = ex_pc[LSB+IDX-1:LSB]     ^ {bu_bp_history, {BP_LOCAL_BITS{1'b0}}};
`else
    assign rd_idx = {bu_bp_history, if_nxt_pc[LSB+BP_LOCAL_BITS-1:LSB]};
    assign wr_idx = {bu_bp_history, ex_pc[LSB+BP_LOCAL_BITS-1:LSB]};
`endif

    assign bp_ready = (state_q == ST_RUN);

    // Saturating counter step computed from the counter the branch carried.
    // The table is not re-read, so back-to-back updates cannot hazard.
    always_comb begin
        upd_val = bu_bp_predict;
        if (bu_bp_btaken) begin
            if (bu_bp_predict != 2'b11) upd_val = bu_bp_predict + 2'd1;
        end else begin
            if (bu_bp_predict != 2'b00) upd_val = bu_bp_predict - 2'd1;
        end
    end

    // Next state and the single table write port.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = wr_idx;
        wr_data = upd_val;
        case (state_q)
            ST_INIT: begin
                wr_en   = 1'b1;
                wr_addr = init_cnt_q;
                wr_data = 2'b01;
                if (init_cnt_q == {IDX{1'b1}}) state_d = ST_RUN;
            end
            ST_RUN: begin
                wr_en = bu_bp_update;
            end
            default: state_d = ST_INIT;
        endcase
    end

    // State register and the initialisation sweep counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 1'b1;
        end
    end

    // Table storage. The table has no reset because the init sweep fills it.
    always_ff @(posedge clk) begin
        if (wr_en) pht[wr_addr] <= wr_data;
    end

    // Registered lookup with write-first forwarding on an index collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bp_bp_predict <= 2'b00;
        end else if (state_q == ST_INIT) begin
            bp_bp_predict <= 2'b00;
        end else if (!if_stall) begin
            if (bu_bp_update && (rd_idx == wr_idx)) bp_bp_predict <= upd_val;
            else                                   bp_bp_predict <= pht[rd_idx];
        end
    end

endmodule

// File: tb/tb_pu_riscv_bp.sv
// Bench for pu_riscv_bp, configured with 2 history bits, 2 local bits and
// no RVC, which gives a 16-entry table.
module tb_pu_riscv_bp;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rstn;
    logic            if_stall;
    logic [XLEN-1:0] if_nxt_pc;
    logic [1:0]      bp_bp_predict;
    logic            bp_ready;
    logic [XLEN-1:0] ex_pc;
    logic [1:0]      bu_bp_history;
    logic [1:0]      bu_bp_predict;
    logic            bu_bp_btaken;
    logic            bu_bp_update;

    int errors = 0;
    int checks = 0;

    pu_riscv_bp #(
        .XLEN(XLEN), .BP_GLOBAL_BITS(2), .BP_LOCAL_BITS(2), .HAS_RVC(0)
    ) dut (
        .clk(clk), .rstn(rstn), .if_stall(if_stall), .if_nxt_pc(if_nxt_pc),
        .bp_bp_predict(bp_bp_predict), .bp_ready(bp_ready), .ex_pc(ex_pc),
        .bu_bp_history(bu_bp_history), .bu_bp_predict(bu_bp_predict),
        .bu_bp_btaken(bu_bp_btaken), .bu_bp_update(bu_bp_update)
    );

    // Clock and reset
    always #5 clk = ~clk;

    // Reference model: a table of small integers, a ready flag, and a cycle count.
    int         m_pht [DEPTH];
    logic       m_ready;
    logic [1:0] m_pred;
    int         m_cnt;
    int         m_ri, m_wi, m_nv;

    function automatic int idx_of(input logic [XLEN-1:0] pc, input logic [1:0] h);
        int p;
        p = int'(pc[5:2]);
`ifdef PU_RISCV_BP_GSHARE_EN
        return p ^ (int'(h) * 4);
`else
        return (int'(h) * 4) + (p % 4);
`endif
    endfunction

    function automatic int sat_step(input logic [1:0] p, input logic t);
        int v;
        v = int'(p) + (t ? 1 : -1);
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ready = 1'b0;
            m_pred  = 2'b00;
            m_cnt   = 0;
        end else if (!m_ready) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DEPTH) begin
                m_ready = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
            end
        end else begin
            m_nv = sat_step(bu_bp_predict, bu_bp_btaken);
            m_ri = idx_of(if_nxt_pc, bu_bp_history);
            m_wi = idx_of(ex_pc, bu_bp_history);
            if (!if_stall) m_pred = (bu_bp_update && m_ri == m_wi) ? m_nv[1:0] : m_pht[m_ri][1:0];
            if (bu_bp_update) m_pht[m_wi] = m_nv;
        end
    end

    // Scoreboard check
    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against the model on every cycle.
    always @(posedge clk) begin
        #4;
        check("model_ready", {1'b0, bp_ready}, {1'b0, m_ready});
        check("model_predict", bp_bp_predict, m_pred);
    end

    // Driver tasks: inputs change 2 time units after the edge and are sampled at the next edge.
    task automatic cyc(input logic st, input logic [XLEN-1:0] pc, input logic [1:0] h,
                       input logic upd, input logic [XLEN-1:0] xpc,
                       input logic [1:0] p, input logic t);
        if_stall      = st;
        if_nxt_pc     = pc;
        bu_bp_history = h;
        bu_bp_update  = upd;
        ex_pc         = xpc;
        bu_bp_predict = p;
        bu_bp_btaken  = t;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 2'b00, 1'b0, '0, 2'b00, 1'b0);
    endtask

    task automatic lookup(input logic [XLEN-1:0] pc, input logic [1:0] h);
        cyc(1'b0, pc, h, 1'b0, '0, 2'b00, 1'b0);
    endtask

    task automatic do_reset();
        bu_bp_update = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_ready", {1'b0, bp_ready}, 2'b00);
        check("rst_predict", bp_bp_predict, 2'b00);
        @(posedge clk);
        #2;
        rstn = 1'b1;
    endtask

    task automatic init_window();
        for (int k = 1; k <= DEPTH; k++) begin
            idle();
            check("init_ready", {1'b0, bp_ready}, (k == DEPTH) ? 2'b01 : 2'b00);
            check("init_predict", bp_bp_predict, 2'b00);
        end
    endtask

    task automatic sweep_all();
        for (int h = 0; h < 4; h++)
            for (int a = 0; a < DEPTH; a++) begin
                lookup(XLEN'(a * 4), 2'(h));
                check("sweep_01", bp_bp_predict, 2'b01);
            end
    endtask

    initial begin
        rstn = 1'b0;
        if_stall = 1'b0; if_nxt_pc = '0; ex_pc = '0;
        bu_bp_history = 2'b00; bu_bp_predict = 2'b00;
        bu_bp_btaken = 1'b0; bu_bp_update = 1'b0;
        @(posedge clk);
        #2;
        check("por_ready", {1'b0, bp_ready}, 2'b00);
        check("por_predict", bp_bp_predict, 2'b00);
        rstn = 1'b1;

        init_window();
        sweep_all();

        // Taken saturation at pc 0x8, history 10
        cyc(1'b1, '0, 2'b10, 1'b1, 64'h8, 2'b01, 1'b1);
        lookup(64'h8, 2'b10);
        check("taken_inc", bp_bp_predict, 2'b10);
        cyc(1'b1, '0, 2'b10, 1'b1, 64'h8, 2'b11, 1'b1);
        lookup(64'h8, 2'b10);
        check("taken_sat", bp_bp_predict, 2'b11);

        // Not-taken saturation at pc 0x4, history 00
        cyc(1'b1, '0, 2'b00, 1'b1, 64'h4, 2'b00, 1'b0);
        lookup(64'h4, 2'b00);
        check("nt_sat", bp_bp_predict, 2'b00);
        cyc(1'b1, '0, 2'b00, 1'b1, 64'h4, 2'b10, 1'b0);
        lookup(64'h4, 2'b00);
        check("nt_dec", bp_bp_predict, 2'b01);

        // Collision with forwarding, then collision under stall
        cyc(1'b0, 64'hC, 2'b01, 1'b1, 64'hC, 2'b01, 1'b1);
        check("collide_fwd", bp_bp_predict, 2'b10);
        lookup(64'h14, 2'b01);
        check("pre_stall", bp_bp_predict, 2'b01);
        cyc(1'b1, 64'h18, 2'b01, 1'b1, 64'h18, 2'b01, 1'b1);
        check("stall_hold", bp_bp_predict, 2'b01);
        lookup(64'h18, 2'b01);
        check("after_stall", bp_bp_predict, 2'b10);

        // Reset mid-RUN, full reinit
        do_reset();
        init_window();
        sweep_all();

        // Reset mid-INIT
        do_reset();
        repeat (5) idle();
        check("midinit_ready", {1'b0, bp_ready}, 2'b00);
        do_reset();
        init_window();

        // History aliasing: gshare folds history into the top index bits
        cyc(1'b1, '0, 2'b01, 1'b1, 64'h0, 2'b01, 1'b1);
        lookup(64'h10, 2'b00);
`ifdef PU_RISCV_BP_GSHARE_EN
        check("gshare_alias", bp_bp_predict, 2'b10);
`else
        check("concat_noalias", bp_bp_predict, 2'b01);
`endif
        lookup(64'h0, 2'b00);
        check("pc0_h0", bp_bp_predict, 2'b01);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
